// File: rtl/wb_master_engine_if.sv
// Wishbone B4 classic-cycle bus bundle between wb_master_engine and the register fabric.
interface wb_master_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8
) ();
    logic              cyc_out;
    logic              stb_out;
    logic              we_out;
    logic [ADDR_W-1:0] adr_out;
    logic [SEL_W-1:0]  sel_out;
    logic [DATA_W-1:0] dat_out;
    logic [DATA_W-1:0] dat_in;
    logic              ack_in;
    logic              err_in;

    modport master (
        output cyc_out, stb_out, we_out, adr_out, sel_out, dat_out,
        input  dat_in, ack_in, err_in
    );

    modport slave (
        input  cyc_out, stb_out, we_out, adr_out, sel_out, dat_out,
        output dat_in, ack_in, err_in
    );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone B4 classic-cycle master running single or incrementing-burst reads/writes
// for a request/response client, with per-beat write-data flow control, bus-error and ack timeout.
module wb_master_engine #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               req_valid_in,
    output logic               req_ready_out,
    input  logic               req_we_in,
    input  logic [ADDR_W-1:0]  req_addr_in,
    input  logic [SEL_W-1:0]   req_sel_in,
    input  logic [LEN_W-1:0]   req_len_in,
    input  logic               wdata_valid_in,
    output logic               wdata_ready_out,
    input  logic [DATA_W-1:0]  wdata_in,
    output logic               rdata_valid_out,
    output logic [DATA_W-1:0]  rdata_out,
    output logic               done_out,
    output logic               err_out,
    wb_master_engine_if.master wb
);
    localparam int   TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int   TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic TMO_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_req_ready;
    logic              r_wdata_ready;
    logic              r_rdata_valid;
    logic              r_done;
    logic              r_err;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_dat;
    logic [DATA_W-1:0] r_rdata;
    logic [LEN_W-1:0]  r_beats;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_accept;
    logic              w_wdata_hs;
    logic              w_tmo_hit;
    logic              w_abort;
    logic              w_beat_done;
    logic              w_last;
    logic              w_finish;

    // Handshakes are qualified by the registered ready/strobe so nothing is taken while reset is settling.
    assign w_accept    = req_valid_in & r_req_ready;
    assign w_wdata_hs  = wdata_valid_in & r_wdata_ready;
    assign w_tmo_hit   = TMO_EN & (r_tmo == TMO_W'(TMO_LAST));
    assign w_abort     = r_stb & (wb.err_in | (w_tmo_hit & ~wb.ack_in));
    assign w_beat_done = r_stb & wb.ack_in & ~w_abort;
    assign w_last      = (r_beats == '0);
    assign w_finish    = w_abort | (w_beat_done & w_last);

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = req_we_in ? ST_WDATA : ST_STROBE;
                else          w_state_next = ST_IDLE;
            end
            ST_WDATA: begin
                if (w_wdata_hs) w_state_next = ST_STROBE;
                else            w_state_next = ST_WDATA;
            end
            ST_STROBE: begin
                if (w_finish)         w_state_next = ST_IDLE;
                else if (w_beat_done) w_state_next = r_we ? ST_WDATA : ST_STROBE;
                else                  w_state_next = ST_STROBE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    // Control outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_req_ready   <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_req_ready   <= (w_state_next == ST_IDLE);
            r_wdata_ready <= (w_state_next == ST_WDATA);
            r_cyc         <= (w_state_next != ST_IDLE);
            r_stb         <= (w_state_next == ST_STROBE);
            r_done        <= w_finish;
            r_err         <= w_abort;
            r_rdata_valid <= w_beat_done & ~r_we;
            if (w_accept)      r_we <= req_we_in;
            else if (w_finish) r_we <= 1'b0;
            else               r_we <= r_we;
            if (r_stb && !w_beat_done && !w_abort) r_tmo <= r_tmo + TMO_W'(1);
            else                                   r_tmo <= '0;
        end
    end

    // Address/beat bookkeeping and data capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_adr   <= '0;
            r_sel   <= '0;
            r_beats <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_adr   <= req_addr_in;
                r_sel   <= req_sel_in;
                r_beats <= req_len_in;
            end else if (w_beat_done && !w_last) begin
                r_adr   <= r_adr + ADDR_W'(1);
                r_beats <= r_beats - LEN_W'(1);
            end else begin
                r_adr   <= r_adr;
                r_beats <= r_beats;
            end
            if (w_wdata_hs) r_dat <= wdata_in;
            else            r_dat <= r_dat;
            if (w_beat_done && !r_we) r_rdata <= wb.dat_in;
            else                      r_rdata <= r_rdata;
        end
    end

    assign req_ready_out   = r_req_ready;
    assign wdata_ready_out = r_wdata_ready;
    assign rdata_valid_out = r_rdata_valid;
    assign rdata_out       = r_rdata;
    assign done_out        = r_done;
    assign err_out         = r_err;
    assign wb.cyc_out      = r_cyc;
    assign wb.stb_out      = r_stb;
    assign wb.we_out       = r_we;
    assign wb.adr_out      = r_adr;
    assign wb.sel_out      = r_sel;
    assign wb.dat_out      = r_dat;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: a beat scoreboard checked every cycle plus literal expectations per scenario.
module tb_wb_master_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready_out, req_we;
    logic [4:0]  req_addr;
    logic [3:0]  req_sel, req_len;
    logic        wdata_valid, wdata_ready_out;
    logic [31:0] wdata;
    logic        rdata_valid_out;
    logic [31:0] rdata_out;
    logic        done_out, err_out;

    wb_master_engine_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    wb_master_engine #(.ADDR_W(5), .DATA_W(32), .LEN_W(4), .TIMEOUT(16)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .req_valid_in    (req_valid),
        .req_ready_out   (req_ready_out),
        .req_we_in       (req_we),
        .req_addr_in     (req_addr),
        .req_sel_in      (req_sel),
        .req_len_in      (req_len),
        .wdata_valid_in  (wdata_valid),
        .wdata_ready_out (wdata_ready_out),
        .wdata_in        (wdata),
        .rdata_valid_out (rdata_valid_out),
        .rdata_out       (rdata_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .wb              (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rdata[$];
    logic        exp_err;
    logic [31:0] wd [16];
    logic [4:0]  t2_adr [4];
    int n_checks = 0, n_errors = 0, n_done = 0, n_rvalid = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {47'h0, req_ready_out, wdata_ready_out, rdata_valid_out, rdata_out, done_out, err_out,
                bus.cyc_out, bus.stb_out, bus.we_out, bus.adr_out, bus.sel_out, bus.dat_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue every beat the request must produce (address wraps mod 32), then present it until accepted.
    task automatic issue(input logic we, input logic [4:0] addr, input logic [3:0] len, input logic [3:0] sel);
        beat_t b;
        int    n;
        for (int i = 0; i <= int'(len); i++) begin
            b.we  = we;
            b.adr = addr + 5'(i);
            b.sel = sel;
            b.dat = we ? wd[i] : 32'h0;
            exp_beats.push_back(b);
        end
        req_we = we; req_addr = addr; req_len = len; req_sel = sel; req_valid = 1'b1;
        n = 0;
        while (!req_ready_out && n < 20) begin step(); n++; end
        chk("req_ready_seen", req_ready_out, 1'b1);
        step();
        req_valid = 1'b0;
        chk("cyc_on_accept", bus.cyc_out, 1'b1);
    endtask

    // Per-cycle compare against the scoreboard and the bus rules.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            chk("reset_outputs", all_outs(), 128'h0);
        end else begin
            chk("ready_vs_cyc", req_ready_out & bus.cyc_out, 1'b0);
            chk("stb_needs_cyc", bus.stb_out & ~bus.cyc_out, 1'b0);
            chk("wready_phase", wdata_ready_out, bus.cyc_out & ~bus.stb_out);
            chk("err_needs_done", err_out & ~done_out, 1'b0);
            if (rdata_valid_out) begin
                n_rvalid++;
                chk("rdata_expected", exp_rdata.size() != 0, 1'b1);
                if (exp_rdata.size() != 0) chk("rdata_value", rdata_out, exp_rdata.pop_front());
            end
            if (bus.cyc_out) begin
                chk("beat_pending", exp_beats.size() != 0, 1'b1);
                if (exp_beats.size() != 0) begin
                    chk("we_out", bus.we_out, exp_beats[0].we);
                    chk("adr_out", bus.adr_out, exp_beats[0].adr);
                    chk("sel_out", bus.sel_out, exp_beats[0].sel);
                    if (bus.stb_out && bus.we_out) chk("dat_out", bus.dat_out, exp_beats[0].dat);
                    if (bus.stb_out && bus.ack_in && !bus.err_in) begin
                        b = exp_beats.pop_front();
                        if (!b.we) exp_rdata.push_back(bus.dat_in);
                    end
                end
            end
            if (done_out) begin
                n_done++;
                chk("done_err", err_out, exp_err);
                if (!exp_err) chk("done_all_beats", exp_beats.size(), 0);
                exp_beats.delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sc, r0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'h0; req_sel = 4'h0; req_len = 4'h0;
        wdata_valid = 1'b0; wdata = 32'h0; bus.ack_in = 1'b0; bus.err_in = 1'b0; bus.dat_in = 32'h0;
        exp_err = 1'b0;
        t2_adr[0] = 5'h1E; t2_adr[1] = 5'h1F; t2_adr[2] = 5'h00; t2_adr[3] = 5'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_all_zero", all_outs(), 128'h0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", req_ready_out, 1'b1);

        // Single read, two wait states.
        exp_err = 1'b0; r0 = n_rvalid; bus.dat_in = 32'hDEADBEEF;
        issue(1'b0, 5'h03, 4'h0, 4'hF);
        chk("t1_stb_rise", bus.stb_out, 1'b1);
        step(); step();
        chk("t1_stb_waiting", bus.stb_out, 1'b1);
        bus.ack_in = 1'b1; step(); bus.ack_in = 1'b0;
        chk("t1_done", done_out, 1'b1);
        chk("t1_err", err_out, 1'b0);
        chk("t1_cyc_low", bus.cyc_out, 1'b0);
        chk("t1_rvalid", rdata_valid_out, 1'b1);
        chk("t1_rdata", rdata_out, 32'hDEADBEEF);
        step();
        chk("t1_done_pulse", done_out, 1'b0);
        chk("t1_rvalid_count", n_rvalid - r0, 1);

        // 4-beat write burst wrapping the address, producer stalls before beat 2.
        exp_err = 1'b0;
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        issue(1'b1, 5'h1E, 4'h3, 4'hF);
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                for (int s = 0; s < 3; s++) begin
                    chk("t2_stall_stb_low", bus.stb_out, 1'b0);
                    step();
                end
            end
            n = 0;
            while (!wdata_ready_out && n < 20) begin step(); n++; end
            chk("t2_wready", wdata_ready_out, 1'b1);
            wdata = wd[b]; wdata_valid = 1'b1; step(); wdata_valid = 1'b0;
            chk("t2_stb", bus.stb_out, 1'b1);
            chk("t2_adr", bus.adr_out, t2_adr[b]);
            chk("t2_dat", bus.dat_out, wd[b]);
            bus.ack_in = 1'b1; step(); bus.ack_in = 1'b0;
        end
        chk("t2_done", done_out, 1'b1);
        chk("t2_err", err_out, 1'b0);
        chk("t2_cyc_low", bus.cyc_out, 1'b0);
        chk("t2_we_low", bus.we_out, 1'b0);
        step();

        // 8-beat read burst against a zero-wait slave.
        exp_err = 1'b0; r0 = n_rvalid; bus.ack_in = 1'b1; bus.dat_in = 32'hC0DE0000;
        issue(1'b0, 5'h08, 4'h7, 4'hF);
        sc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.dat_in = 32'hC0DE0000 + 32'(i);
            if (bus.stb_out) sc++;
            step();
        end
        bus.ack_in = 1'b0;
        chk("t3_stb_cycles", sc, 8);
        chk("t3_stb_low", bus.stb_out, 1'b0);
        chk("t3_done", done_out, 1'b1);
        chk("t3_err", err_out, 1'b0);
        chk("t3_last_rdata", rdata_out, 32'hC0DE0007);
        step();
        chk("t3_rvalid_count", n_rvalid - r0, 8);

        // Slave never answers: abort after 16 strobe cycles.
        exp_err = 1'b1;
        issue(1'b0, 5'h05, 4'h0, 4'hF);
        sc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.stb_out) break;
            sc++;
            step();
        end
        chk("t4_stb_cycles", sc, 16);
        chk("t4_done", done_out, 1'b1);
        chk("t4_err", err_out, 1'b1);
        chk("t4_cyc_low", bus.cyc_out, 1'b0);
        step();

        // ack and err together on beat 2 of a 4-beat read.
        exp_err = 1'b1; r0 = n_rvalid;
        issue(1'b0, 5'h10, 4'h3, 4'hC);
        bus.dat_in = 32'h12345678; bus.ack_in = 1'b1; step();
        bus.dat_in = 32'h99999999; bus.err_in = 1'b1; step();
        bus.ack_in = 1'b0; bus.err_in = 1'b0;
        chk("t5_done", done_out, 1'b1);
        chk("t5_err", err_out, 1'b1);
        chk("t5_cyc_low", bus.cyc_out, 1'b0);
        chk("t5_no_rvalid", rdata_valid_out, 1'b0);
        step(); step();
        chk("t5_rvalid_count", n_rvalid - r0, 1);
        chk("t5_rdata_held", rdata_out, 32'h12345678);

        // Reset pulse in the middle of a read burst, then a fresh write.
        exp_err = 1'b0; r0 = n_done;
        issue(1'b0, 5'h02, 4'h3, 4'hF);
        bus.dat_in = 32'hABCD0001; bus.ack_in = 1'b1; step(); bus.ack_in = 1'b0;
        step();
        chk("t6_mid_cyc", bus.cyc_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_zero", all_outs(), 128'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_beats.delete(); exp_rdata.delete();
        step(); step();
        chk("t6_no_done", n_done - r0, 0);
        chk("t6_ready", req_ready_out, 1'b1);
        wd[0] = 32'hCAFEF00D;
        issue(1'b1, 5'h07, 4'h0, 4'h5);
        chk("t6_wready", wdata_ready_out, 1'b1);
        wdata = wd[0]; wdata_valid = 1'b1; step(); wdata_valid = 1'b0;
        chk("t6_dat", bus.dat_out, 32'hCAFEF00D);
        bus.ack_in = 1'b1; step(); bus.ack_in = 1'b0;
        chk("t6_done", done_out, 1'b1);
        chk("t6_err", err_out, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
